div_seq: RTL

- Parametrised multi-cycle unsigned integer divider; the next generation of the existing `div` block.
- Computes q = x / y and r = x % y, one quotient bit per cycle (restoring shift-subtract).
- Adds over `div`: a width parameter, an async reset, a busy indicator, a divide-by-zero flag and an optional signed mode.
- Serves the PRNG datapath (Park-Miller Schrage decomposition: 16807-based quotient/remainder) and any other long-latency divide.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_if.sv | 22 ++
 rtl/div_step.sv | 30 +++
 rtl/div_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the sequential divider.
//   div_state_t  : controller states (IDLE, RUN, FIN)
//   DIV_WIDTH_DEF: default operand width
//   dz_quot_bit  : bit i of the quotient reported for a zero divisor
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEF = 32;

  // Zero-divisor quotient: all ones (-1), or +1 when a signed dividend is
  // negative. Evaluated per bit so callers of any width avoid slicing.
  function automatic logic dz_quot_bit(input logic x_neg, input int i);
    return x_neg ? (i == 0) : 1'b1;
  endfunction

endpackage

// File: rtl/div_if.sv
// div_if: start/operand/result bundle of div_seq.
//   en, x, y          : start request and operands (master -> slave)
//   q, r, done, busy, dz : results and status       (slave -> master)
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
);

  logic             en;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             done;
  logic             busy;
  logic             dz;

  modport master (output en, x, y, input q, r, done, busy, dz);
  modport slave  (input en, x, y, output q, r, done, busy, dz);

endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   rem_i/quo_i : partial remainder and dividend/quotient shift register
//   dvs_i       : divisor
//   rem_o/quo_o : values after shift, compare and conditional subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // One extra bit so a remainder above half-range still compares correctly.
    shifted = {rem_i, quo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs_i});
    // When ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    diff    = shifted[WIDTH-1:0] - dvs_i;
    rem_o   = ge ? diff : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : div_if slave (en/x/y in; q/r/done/busy/dz out)
// A start is accepted in IDLE; WIDTH RUN cycles, one FIN cycle, then done
// pulses with q/r/dz, which hold until the next completion.
// Optional macro DIV_SIGNED_EN: two's-complement operands, quotient truncated
// toward zero, remainder carrying the dividend's sign.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             dz_neg;
`ifdef DIV_SIGNED_EN
  logic             xneg_q, xneg_d;
  logic             qneg_q, qneg_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Final sign correction, applied as results are registered in FIN.
  always_comb begin
`ifdef DIV_SIGNED_EN
    q_fix  = qneg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix  = xneg_q ? (~rem_q + 1'b1) : rem_q;
    dz_neg = xneg_q;
`else
    q_fix  = quo_q;
    r_fix  = rem_q;
    dz_neg = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    xneg_d  = xneg_q;
    qneg_d  = qneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.en) begin
`ifdef DIV_SIGNED_EN
          // Divide magnitudes; MIN's magnitude is exact as an unsigned value.
          xneg_d = bus.x[WIDTH-1];
          qneg_d = bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
          quo_d  = bus.x[WIDTH-1] ? (~bus.x + 1'b1) : bus.x;
          dvs_d  = bus.y[WIDTH-1] ? (~bus.y + 1'b1) : bus.y;
`else
          quo_d  = bus.x;
          dvs_d  = bus.y;
`endif
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        q_d    = q_fix;
        r_d    = r_fix;
        dz_d   = (dvs_q == '0);
        // A zero divisor leaves x in the remainder naturally; the quotient
        // pattern is forced so it does not depend on iteration details.
        if (dvs_q == '0) begin
          for (int i = 0; i < WIDTH; i++) q_d[i] = dz_quot_bit(dz_neg, i);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      xneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      xneg_q  <= xneg_d;
      qneg_q  <= qneg_d;
`endif
    end
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.dz   = dz_q;

endmodule
